// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle for imm_gen_pipe: instruction handshake in,
// immediate handshake out. The master drives requests and consumes results.
`timescale 1ns/1ps
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [4:0]       sext_ope;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, inst, sext_ope, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, inst, sext_ope, in_tag, out_ready,
        output in_ready, out_valid, imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a two-entry skid buffer (main + skid).
// Define IMM_GEN_RVC_EN to compile in the compressed CI/CB/CJ decoders.
`timescale 1ns/1ps
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);
    localparam logic [4:0] IMM_I  = 5'd0;
    localparam logic [4:0] IMM_S  = 5'd1;
    localparam logic [4:0] IMM_B  = 5'd2;
    localparam logic [4:0] IMM_J  = 5'd3;
    localparam logic [4:0] IMM_U  = 5'd4;
`ifdef IMM_GEN_RVC_EN
    localparam logic [4:0] IMM_CI = 5'd5;
    localparam logic [4:0] IMM_CB = 5'd6;
    localparam logic [4:0] IMM_CJ = 5'd7;
`endif

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    state_t      state, state_next;
    entry_t      main_q, skid_q, dec;
    logic [31:0] raw;
    logic        accept, deq;
    logic        load_main, main_from_skid, load_skid;

    // Every format is first sign-extended to 32 bits, then widened to XLEN.
    always_comb begin
        raw         = '0;
        dec.illegal = 1'b0;
        unique case (bus.sext_ope)
            IMM_I:  raw = {{20{bus.inst[31]}}, bus.inst[31:20]};
            IMM_S:  raw = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            IMM_B:  raw = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                           bus.inst[30:25], bus.inst[11:8], 1'b0};
            IMM_J:  raw = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                           bus.inst[20], bus.inst[30:21], 1'b0};
            IMM_U:  raw = {bus.inst[31:12], 12'b0};
`ifdef IMM_GEN_RVC_EN
            IMM_CI: raw = {{26{bus.inst[12]}}, bus.inst[12], bus.inst[6:2]};
            IMM_CB: raw = {{23{bus.inst[12]}}, bus.inst[12], bus.inst[6:5],
                           bus.inst[2], bus.inst[11:10], bus.inst[4:3], 1'b0};
            IMM_CJ: raw = {{20{bus.inst[12]}}, bus.inst[12], bus.inst[8],
                           bus.inst[10:9], bus.inst[6], bus.inst[7], bus.inst[2],
                           bus.inst[11], bus.inst[5:3], 1'b0};
`endif
            default: dec.illegal = 1'b1;
        endcase
        dec.imm       = {XLEN{raw[31]}};
        dec.imm[31:0] = raw;
        dec.tag       = bus.in_tag;
    end

    assign bus.in_ready    = (state != FULL);
    assign bus.out_valid   = (state != EMPTY);
    assign bus.imm         = main_q.imm;
    assign bus.out_tag     = main_q.tag;
    assign bus.out_illegal = main_q.illegal;

    assign accept = bus.in_valid && bus.in_ready;
    assign deq    = bus.out_valid && bus.out_ready;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deq) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (accept && deq) begin
                    load_main  = 1'b1;
                end else if (deq) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main)
                main_q <= dec;
            else if (main_from_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are checked against a field-arithmetic reference model.
`timescale 1ns/1ps
module tb_imm_gen_pipe;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      inst = '0;
    logic [4:0]       ope = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             out_ready = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.inst      = inst;
    assign bus32.sext_ope  = ope;
    assign bus32.in_tag    = tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.inst      = inst;
    assign bus64.sext_ope  = ope;
    assign bus64.in_tag    = tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        bit               ill;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    bit   rnd_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        return (longint'(w) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Immediate value as a signed integer assembled from weighted fields.
    function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] w, output bit ill);
        longint v = 0;
        int     n = 0;
        ill = 1'b0;
        case (o)
            5'd0: begin v = fld(w, 31, 20); n = 12; end
            5'd1: begin v = fld(w, 31, 25) * 32 + fld(w, 11, 7); n = 12; end
            5'd2: begin v = fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048
                          + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2; n = 13; end
            5'd3: begin v = fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096
                          + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2; n = 21; end
            5'd4: begin v = fld(w, 31, 12) * 4096; n = 32; end
`ifdef IMM_GEN_RVC_EN
            5'd5: begin v = fld(w, 12, 12) * 32 + fld(w, 6, 2); n = 6; end
            5'd6: begin v = fld(w, 12, 12) * 256 + fld(w, 6, 5) * 64 + fld(w, 2, 2) * 32
                          + fld(w, 11, 10) * 8 + fld(w, 4, 3) * 2; n = 9; end
            5'd7: begin v = fld(w, 12, 12) * 2048 + fld(w, 8, 8) * 1024 + fld(w, 10, 9) * 256
                          + fld(w, 6, 6) * 128 + fld(w, 7, 7) * 64 + fld(w, 2, 2) * 32
                          + fld(w, 11, 11) * 16 + fld(w, 5, 3) * 2; n = 12; end
`endif
            default: begin v = 0; n = 0; ill = 1'b1; end
        endcase
        if (n > 0 && v >= (longint'(1) << (n - 1)))
            v -= (longint'(1) << n);
        return 64'(v);
    endfunction

    // Holds the request until accepted; the expectation is queued at the accepting edge.
    task automatic send(input logic [4:0] o, input logic [31:0] w, input logic [TAG_W-1:0] t,
                        input bit use_fix, input logic [63:0] fix_imm, input bit fix_ill);
        bit   acc  = 1'b0;
        bit   done = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        ope = o;
        inst = w;
        tag = t;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            acc = bus32.in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) begin
                if (use_fix) begin
                    e.imm = fix_imm;
                    e.ill = fix_ill;
                end else begin
                    e.imm = model(o, w, e.ill);
                end
                e.tag = t;
                q.push_back(e);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", t);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [63:0]      p_imm32, p_imm64;
    logic [TAG_W-1:0] p_tag;
    logic             p_ill;
    bit               prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("in_ready32", 64'(bus32.in_ready), 64'(q.size() < 2));
            check("in_ready64", 64'(bus64.in_ready), 64'(q.size() < 2));
            check("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
            check("out_valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
            if (prev_stall) begin
                check("stable_imm32", 64'(bus32.imm), p_imm32);
                check("stable_imm64", bus64.imm, p_imm64);
                check("stable_tag", 64'(bus32.out_tag), 64'(p_tag));
                check("stable_ill", 64'(bus32.out_illegal), 64'(p_ill));
            end
            if (!rst && bus32.out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=valid required=empty tag=%0d", bus32.out_tag);
                end else begin
                    e = q.pop_front();
                    check("imm32", 64'(bus32.imm), 64'(e.imm[31:0]));
                    check("imm64", bus64.imm, e.imm);
                    check("tag32", 64'(bus32.out_tag), 64'(e.tag));
                    check("tag64", 64'(bus64.out_tag), 64'(e.tag));
                    check("ill32", 64'(bus32.out_illegal), 64'(e.ill));
                    check("ill64", 64'(bus64.out_illegal), 64'(e.ill));
                end
            end
            prev_stall = bus32.out_valid && !out_ready && !rst;
            p_imm32 = 64'(bus32.imm);
            p_imm64 = bus64.imm;
            p_tag   = bus32.out_tag;
            p_ill   = bus32.out_illegal;
        end
    end

    initial begin
        int budget;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst_imm32", 64'(bus32.imm), 64'd0);
        check("rst_imm64", bus64.imm, 64'd0);
        check("rst_tag", 64'(bus32.out_tag), 64'd0);
        check("rst_ill", 64'(bus32.out_illegal), 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(5'd0, 32'hFFF00093, 4'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(5'd4, 32'h80000037, 4'd4, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send(5'd4, 32'h12345037, 4'd5, 1'b1, 64'h0000_0000_1234_5000, 1'b0);
        send(5'd2, 32'hFE000EE3, 4'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
`ifdef IMM_GEN_RVC_EN
        send(5'd5, 32'h000050FD, 4'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`else
        send(5'd5, 32'h000050FD, 4'd7, 1'b1, 64'h0, 1'b1);
`endif
        send(5'd20, 32'hFFFFFFFF, 4'd8, 1'b1, 64'h0, 1'b1);
        send(5'd1, 32'hFE000FA3, 4'd9, 1'b0, 64'h0, 1'b0);
        send(5'd3, 32'h8000006F, 4'd10, 1'b0, 64'h0, 1'b0);
        idle(3);

        out_ready = 1'b0;
        send(5'd0, 32'h00100093, 4'd1, 1'b0, 64'h0, 1'b0);
        send(5'd0, 32'h00200093, 4'd2, 1'b0, 64'h0, 1'b0);
        fork
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join_none
        send(5'd0, 32'h00300093, 4'd3, 1'b0, 64'h0, 1'b0);
        idle(5);

        out_ready = 1'b0;
        send(5'd4, 32'hABCDE037, 4'd5, 1'b0, 64'h0, 1'b0);
        send(5'd2, 32'h00000463, 4'd6, 1'b0, 64'h0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        ope = 5'd0;
        inst = 32'h7FF00093;
        tag = 4'd7;
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(bus32.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus32.in_ready), 64'd1);
        idle(4);

        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2) == 0 ? 1 : 0);
            send(5'($urandom_range(0, 9)), $urandom, TAG_W'($urandom), 1'b0, 64'h0, 1'b0);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", q.size());
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
